// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline stall/flush controller: FSM encodings,
// register-zero address and default timing parameters.
package pipe_ctrl_pkg;

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_DIV_WAIT = 2'd1;
  localparam logic [1:0] ST_MEM_WAIT = 2'd2;
  localparam logic [1:0] ST_FLUSH    = 2'd3;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam int DIV_CYCLES_DEFAULT   = 32;
  localparam int FLUSH_CYCLES_DEFAULT = 1;

  // Dependency checker slots
  localparam int DEP_EX_LOAD  = 0;
  localparam int DEP_EX_MFC0  = 1;
  localparam int DEP_MEM_MFC0 = 2;
  localparam int NUM_DEP      = 3;

  typedef logic [4:0] reg_addr_t;

endpackage

// File: rtl/hazard_dep_chk.sv
// Combinational check: does the ID instruction read register rd?
// Register $0 never produces a dependency.
module hazard_dep_chk
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] rs,
  input  logic [4:0] rt,
  input  logic       rs_used,
  input  logic       rt_used,
  input  logic [4:0] rd,
  output logic       dep
);

  logic rs_hit;
  logic rt_hit;

  assign rs_hit = rs_used & (rs == rd) & (rd != REG_ZERO);
  assign rt_hit = rt_used & (rt == rd) & (rd != REG_ZERO);
  assign dep    = rs_hit | rt_hit;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush scheduler for the 5-stage pipeline (flush > freeze > bubbles).
// Optional perf counters enabled with `define PIPE_HAZARD_CTRL_PERF_EN.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int DIV_CYCLES   = DIV_CYCLES_DEFAULT,
  parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEFAULT
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_rs_used,
  input  logic       id_rt_used,
  input  logic [4:0] ex_rd,
  input  logic       ex_rf_we,
  input  logic       ex_is_load,
  input  logic       ex_is_mfc0,
  input  logic [4:0] mem_rd,
  input  logic       mem_rf_we,
  input  logic       mem_is_mfc0,
  input  logic       div_issue,
  input  logic       ram_wait,
  input  logic       cp0_ex_commit,
  input  logic       cp0_eret,
  output logic       pc_stall,
  output logic       ifid_stall,
  output logic       hazard_stall,
  output logic       exe_stall,
  output logic       ie_mfc0_hazard_stall,
  output logic       im_mfc0_hazard_stall,
  output logic       int_flush,
  output logic [1:0] ctrl_state
`ifdef PIPE_HAZARD_CTRL_PERF_EN
  ,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt
`endif
);

  localparam int DW = (DIV_CYCLES < 1) ? 1 : $clog2(DIV_CYCLES + 1);
  localparam int FW = (FLUSH_CYCLES < 1) ? 1 : $clog2(FLUSH_CYCLES + 1);

  logic [1:0]    state_reg, state_next;
  logic [DW-1:0] div_cnt_reg, div_cnt_next;
  logic [FW-1:0] flush_cnt_reg, flush_cnt_next;

  logic              freeze;
  logic              flush;
  logic              bubble_en;
  logic [NUM_DEP-1:0] dep;
  reg_addr_t         chk_rd [NUM_DEP];

  logic b_load;
  logic b_ie;
  logic b_im;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DEP; gi++) begin : g_dep
      assign chk_rd[gi] = (gi == DEP_MEM_MFC0) ? mem_rd : ex_rd;
      hazard_dep_chk u_dep (
        .rs      (id_rs),
        .rt      (id_rt),
        .rs_used (id_rs_used),
        .rt_used (id_rt_used),
        .rd      (chk_rd[gi]),
        .dep     (dep[gi])
      );
    end
  endgenerate

  // A non-zero div_cnt means a divide is still occupying EX, whether we are
  // in DIV_WAIT or parked in MEM_WAIT; leaving MEM_WAIT resumes the countdown
  // in the same cycle so the freeze stays continuous.
  always_comb begin
    state_next     = state_reg;
    div_cnt_next   = div_cnt_reg;
    flush_cnt_next = flush_cnt_reg;
    freeze         = 1'b0;
    flush          = 1'b0;
    bubble_en      = 1'b0;
    if (cp0_ex_commit | cp0_eret) begin
      flush          = 1'b1;
      div_cnt_next   = '0;
      flush_cnt_next = FW'(FLUSH_CYCLES);
      state_next     = (FLUSH_CYCLES == 0) ? ST_RUN : ST_FLUSH;
    end else if (state_reg == ST_FLUSH) begin
      flush          = 1'b1;
      flush_cnt_next = flush_cnt_reg - FW'(1);
      if (flush_cnt_reg <= FW'(1)) begin
        flush_cnt_next = '0;
        state_next     = ST_RUN;
      end
    end else if (ram_wait) begin
      freeze     = 1'b1;
      state_next = ST_MEM_WAIT;
    end else if (div_cnt_reg != '0) begin
      freeze       = 1'b1;
      div_cnt_next = div_cnt_reg - DW'(1);
      state_next   = (div_cnt_reg == DW'(1)) ? ST_RUN : ST_DIV_WAIT;
    end else begin
      bubble_en  = 1'b1;
      state_next = ST_RUN;
      if (div_issue) begin
        div_cnt_next = DW'(DIV_CYCLES);
        state_next   = (DIV_CYCLES == 0) ? ST_RUN : ST_DIV_WAIT;
      end
    end
  end

  assign b_load = bubble_en & ex_is_load  & ex_rf_we  & dep[DEP_EX_LOAD];
  assign b_ie   = bubble_en & ex_is_mfc0  & ex_rf_we  & dep[DEP_EX_MFC0];
  assign b_im   = bubble_en & mem_is_mfc0 & mem_rf_we & dep[DEP_MEM_MFC0];

  // Outputs are forced quiet while reset is asserted
  assign hazard_stall         = resetn & b_load;
  assign ie_mfc0_hazard_stall = resetn & b_ie;
  assign im_mfc0_hazard_stall = resetn & b_im;
  assign exe_stall            = resetn & freeze;
  assign pc_stall             = resetn & (freeze | b_load | b_ie | b_im);
  assign ifid_stall           = pc_stall;
  assign int_flush            = resetn & flush;
  assign ctrl_state           = resetn ? state_reg : ST_RUN;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg     <= ST_RUN;
      div_cnt_reg   <= '0;
      flush_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      div_cnt_reg   <= div_cnt_next;
      flush_cnt_reg <= flush_cnt_next;
    end
  end

`ifdef PIPE_HAZARD_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (!resetn) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (pc_stall && (perf_stall_cnt != 32'hFFFF_FFFF))
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (int_flush && (perf_flush_cnt != 32'hFFFF_FFFF))
        perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios with literal
// expectations, then randomized traffic checked against a cycle model.
module tb_pipe_hazard_ctrl;

  localparam int DIVC = 32;
  localparam int FLC  = 1;

  logic       clk;
  logic       resetn;
  logic [4:0] id_rs, id_rt;
  logic       id_rs_used, id_rt_used;
  logic [4:0] ex_rd;
  logic       ex_rf_we, ex_is_load, ex_is_mfc0;
  logic [4:0] mem_rd;
  logic       mem_rf_we, mem_is_mfc0;
  logic       div_issue, ram_wait, cp0_ex_commit, cp0_eret;
  logic       pc_stall, ifid_stall, hazard_stall, exe_stall;
  logic       ie_mfc0_hazard_stall, im_mfc0_hazard_stall, int_flush;
  logic [1:0] ctrl_state;
`ifdef PIPE_HAZARD_CTRL_PERF_EN
  logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif

  pipe_hazard_ctrl #(.DIV_CYCLES(DIVC), .FLUSH_CYCLES(FLC)) dut (
    .clk                  (clk),
    .resetn               (resetn),
    .id_rs                (id_rs),
    .id_rt                (id_rt),
    .id_rs_used           (id_rs_used),
    .id_rt_used           (id_rt_used),
    .ex_rd                (ex_rd),
    .ex_rf_we             (ex_rf_we),
    .ex_is_load           (ex_is_load),
    .ex_is_mfc0           (ex_is_mfc0),
    .mem_rd               (mem_rd),
    .mem_rf_we            (mem_rf_we),
    .mem_is_mfc0          (mem_is_mfc0),
    .div_issue            (div_issue),
    .ram_wait             (ram_wait),
    .cp0_ex_commit        (cp0_ex_commit),
    .cp0_eret             (cp0_eret),
    .pc_stall             (pc_stall),
    .ifid_stall           (ifid_stall),
    .hazard_stall         (hazard_stall),
    .exe_stall            (exe_stall),
    .ie_mfc0_hazard_stall (ie_mfc0_hazard_stall),
    .im_mfc0_hazard_stall (im_mfc0_hazard_stall),
    .int_flush            (int_flush),
    .ctrl_state           (ctrl_state)
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    ,
    .perf_stall_cnt       (perf_stall_cnt),
    .perf_flush_cnt       (perf_flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit check_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Remaining flush cycles, remaining divide occupancy, and whether the RAM
  // stall was the action taken last cycle.
  int          m_flush_left = 0;
  int          m_div_left   = 0;
  bit          m_mem        = 1'b0;
  logic [31:0] m_perf_stall = '0;
  logic [31:0] m_perf_flush = '0;

  typedef struct packed {
    logic       flush, exe, hz, ie, im, pc, ifid;
    logic [1:0] st;
  } exp_t;

  exp_t exp_now;

  function automatic bit dep_on(input logic [4:0] r);
    return (r != 5'd0) && ((id_rs_used && id_rs == r) || (id_rt_used && id_rt == r));
  endfunction

  always_comb begin
    exp_now = '0;
    if (resetn) begin
      exp_now.st = (m_flush_left > 0) ? 2'd3 : m_mem ? 2'd2 : (m_div_left > 0) ? 2'd1 : 2'd0;
      if (cp0_ex_commit || cp0_eret || m_flush_left > 0) begin
        exp_now.flush = 1'b1;
      end else if (ram_wait || m_div_left > 0) begin
        exp_now.exe = 1'b1;
      end else begin
        exp_now.hz = ex_is_load  && ex_rf_we  && dep_on(ex_rd);
        exp_now.ie = ex_is_mfc0  && ex_rf_we  && dep_on(ex_rd);
        exp_now.im = mem_is_mfc0 && mem_rf_we && dep_on(mem_rd);
      end
      exp_now.pc   = exp_now.exe | exp_now.hz | exp_now.ie | exp_now.im;
      exp_now.ifid = exp_now.pc;
    end
  end

  initial forever begin
    @(posedge clk);
    if (!resetn) begin
      m_flush_left = 0;
      m_div_left   = 0;
      m_mem        = 1'b0;
      m_perf_stall = '0;
      m_perf_flush = '0;
    end else begin
      if (exp_now.pc && m_perf_stall != 32'hFFFF_FFFF) m_perf_stall = m_perf_stall + 1;
      if (exp_now.flush && m_perf_flush != 32'hFFFF_FFFF) m_perf_flush = m_perf_flush + 1;
      if (cp0_ex_commit || cp0_eret) begin
        m_div_left   = 0;
        m_flush_left = FLC;
        m_mem        = 1'b0;
      end else if (m_flush_left > 0) begin
        m_flush_left = m_flush_left - 1;
        m_mem        = 1'b0;
      end else if (ram_wait) begin
        m_mem = 1'b1;
      end else begin
        m_mem = 1'b0;
        if (m_div_left > 0) m_div_left = m_div_left - 1;
        else if (div_issue) m_div_left = DIVC;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge clk);
    #2;
    if (check_en) begin
      chk("int_flush",    32'(int_flush),            32'(exp_now.flush));
      chk("exe_stall",    32'(exe_stall),            32'(exp_now.exe));
      chk("hazard_stall", 32'(hazard_stall),         32'(exp_now.hz));
      chk("ie_mfc0",      32'(ie_mfc0_hazard_stall), 32'(exp_now.ie));
      chk("im_mfc0",      32'(im_mfc0_hazard_stall), 32'(exp_now.im));
      chk("pc_stall",     32'(pc_stall),             32'(exp_now.pc));
      chk("ifid_stall",   32'(ifid_stall),           32'(exp_now.ifid));
      chk("ctrl_state",   32'(ctrl_state),           32'(exp_now.st));
`ifdef PIPE_HAZARD_CTRL_PERF_EN
      chk("perf_stall",   perf_stall_cnt,            m_perf_stall);
      chk("perf_flush",   perf_flush_cnt,            m_perf_flush);
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    resetn = 1'b1;
    id_rs = '0; id_rt = '0; id_rs_used = 1'b0; id_rt_used = 1'b0;
    ex_rd = '0; ex_rf_we = 1'b0; ex_is_load = 1'b0; ex_is_mfc0 = 1'b0;
    mem_rd = '0; mem_rf_we = 1'b0; mem_is_mfc0 = 1'b0;
    div_issue = 1'b0; ram_wait = 1'b0; cp0_ex_commit = 1'b0; cp0_eret = 1'b0;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int len, first, last, bad;
    idle();
    resetn = 1'b0;
    tick(); tick();

    // Reset with aggressive inputs: everything quiet
    check_en = 1'b1;
    tick();
    resetn = 1'b0; cp0_ex_commit = 1'b1; ram_wait = 1'b1;
    ex_is_load = 1'b1; ex_rf_we = 1'b1; ex_rd = 5'd3; id_rs = 5'd3; id_rs_used = 1'b1;
    #3;
    chk("rst_flush", 32'(int_flush), 0);
    chk("rst_pc", 32'(pc_stall), 0);
    chk("rst_hz", 32'(hazard_stall), 0);
    chk("rst_state", 32'(ctrl_state), 0);

    // Load-use on rs=5: one-cycle bubble
    tick(); idle();
    id_rs = 5'd5; id_rs_used = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd5; ex_rf_we = 1'b1;
    #3;
    chk("lu_hz", 32'(hazard_stall), 1);
    chk("lu_pc", 32'(pc_stall), 1);
    chk("lu_ifid", 32'(ifid_stall), 1);
    chk("lu_exe", 32'(exe_stall), 0);
    tick(); idle();
    #3;
    chk("lu_hz_gone", 32'(hazard_stall), 0);
    tick(); idle();
    id_rs = 5'd0; id_rs_used = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd0; ex_rf_we = 1'b1;
    #3;
    chk("lu_r0", 32'(hazard_stall), 0);

    // Divide: 32 frozen cycles following the issue cycle
    tick(); idle(); div_issue = 1'b1;
    #3;
    chk("div_issue_nostall", 32'(exe_stall), 0);
    len = 0; first = 0; last = 0; bad = 0;
    for (int i = 1; i <= 40; i++) begin
      tick(); idle();
      #3;
      if (exe_stall) begin
        len++;
        if (first == 0) first = i;
        last = i;
        if (ctrl_state != 2'd1) bad++;
      end
    end
    chk("div_len", 32'(len), 32);
    chk("div_first", 32'(first), 1);
    chk("div_last", 32'(last), 32);
    chk("div_state_bad", 32'(bad), 0);

    // RAM wait at div_cnt=10: total freeze 32+3, continuous
    tick(); idle(); div_issue = 1'b1;
    len = 0; first = 0; last = 0;
    for (int i = 1; i <= 45; i++) begin
      tick(); idle();
      if (i >= 23 && i <= 25) ram_wait = 1'b1;
      #3;
      if (i == 24 || i == 25 || i == 26) chk("memwait_state", 32'(ctrl_state), 2);
      if (i == 27) chk("divwait_resume", 32'(ctrl_state), 1);
      if (exe_stall) begin
        len++;
        if (first == 0) first = i;
        last = i;
      end
    end
    chk("ramdiv_len", 32'(len), 35);
    chk("ramdiv_span", 32'(last - first + 1), 35);

    // Exception at div_cnt=20
    tick(); idle(); div_issue = 1'b1;
    for (int i = 1; i <= 12; i++) begin tick(); idle(); end
    tick(); idle(); cp0_ex_commit = 1'b1;
    #3;
    chk("exc_flush0", 32'(int_flush), 1);
    chk("exc_exe0", 32'(exe_stall), 0);
    tick(); idle();
    #3;
    chk("exc_flush1", 32'(int_flush), 1);
    chk("exc_state1", 32'(ctrl_state), 3);
    chk("exc_exe1", 32'(exe_stall), 0);
    tick(); idle();
    #3;
    chk("exc_flush2", 32'(int_flush), 0);
    chk("exc_exe2", 32'(exe_stall), 0);
    chk("exc_state2", 32'(ctrl_state), 0);

    // Simultaneous EX and MEM mfc0 dependencies, then under a RAM freeze
    tick(); idle();
    ex_is_mfc0 = 1'b1; ex_rf_we = 1'b1; ex_rd = 5'd7; id_rt = 5'd7; id_rt_used = 1'b1;
    mem_is_mfc0 = 1'b1; mem_rf_we = 1'b1; mem_rd = 5'd9; id_rs = 5'd9; id_rs_used = 1'b1;
    #3;
    chk("sim_ie", 32'(ie_mfc0_hazard_stall), 1);
    chk("sim_im", 32'(im_mfc0_hazard_stall), 1);
    chk("sim_hz", 32'(hazard_stall), 0);
    ram_wait = 1'b1;
    #1;
    chk("simram_exe", 32'(exe_stall), 1);
    chk("simram_ie", 32'(ie_mfc0_hazard_stall), 0);
    chk("simram_im", 32'(im_mfc0_hazard_stall), 0);

    // Reset in the middle of FLUSH
    tick(); idle(); cp0_eret = 1'b1;
    tick(); idle(); resetn = 1'b0;
    #3;
    chk("rstfl_flush", 32'(int_flush), 0);
    chk("rstfl_state", 32'(ctrl_state), 0);
    tick(); idle();
    #3;
    chk("postrst_flush", 32'(int_flush), 0);
    chk("postrst_state", 32'(ctrl_state), 0);
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    chk("postrst_perf_stall", perf_stall_cnt, 0);
    chk("postrst_perf_flush", perf_flush_cnt, 0);
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      tick();
      resetn        = ($urandom_range(0, 299) != 0);
      cp0_ex_commit = ($urandom_range(0, 59) == 0);
      cp0_eret      = ($urandom_range(0, 79) == 0);
      ram_wait      = ($urandom_range(0, 7) == 0);
      div_issue     = ($urandom_range(0, 24) == 0);
      id_rs         = 5'($urandom_range(0, 3));
      id_rt         = 5'($urandom_range(0, 3));
      id_rs_used    = ($urandom_range(0, 1) == 0);
      id_rt_used    = ($urandom_range(0, 1) == 0);
      ex_rd         = 5'($urandom_range(0, 3));
      ex_rf_we      = ($urandom_range(0, 3) != 0);
      ex_is_load    = ($urandom_range(0, 2) == 0);
      ex_is_mfc0    = ($urandom_range(0, 2) == 0);
      mem_rd        = 5'($urandom_range(0, 3));
      mem_rf_we     = ($urandom_range(0, 3) != 0);
      mem_is_mfc0   = ($urandom_range(0, 2) == 0);
    end

    tick(); idle();
    tick();
    #3;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush scheduler for the 5-stage pipeline.
- Drives the stall and flush inputs of the PC, IF/ID and ID/EX pipe registers: hazard_stall, exe_stall, int_flush, ie_mfc0_hazard_stall and im_mfc0_hazard_stall.
- Resolves four hazard sources with a fixed priority:
  - load-use and mfc0-use data hazards;
  - multi-cycle divide occupancy;
  - data-RAM wait;
  - exception/eret flush.
- Sits beside the ID stage; purely control, no datapath.

Parameters:
- DIV_CYCLES, 32: EX-occupancy cycles of a divide after issue.
- FLUSH_CYCLES, 1: extra cycles int_flush is held after the triggering event.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- id_rs  in  5  rs address of the instruction in ID
- id_rt  in  5  rt address of the instruction in ID
- id_rs_used  in  1  ID instruction reads rs
- id_rt_used  in  1  ID instruction reads rt
- ex_rd  in  5  destination register in EX
- ex_rf_we  in  1  EX writes the register file
- ex_is_load  in  1  EX holds a load
- ex_is_mfc0  in  1  EX holds mfc0
- mem_rd  in  5  destination register in MEM
- mem_rf_we  in  1  MEM writes the register file
- mem_is_mfc0  in  1  MEM holds mfc0
- div_issue  in  1  divide leaving ID this cycle
- ram_wait  in  1  data RAM not ready
- cp0_ex_commit  in  1  exception taken at commit
- cp0_eret  in  1  eret committed
- pc_stall  out  1  hold PC
- ifid_stall  out  1  hold IF/ID
- hazard_stall  out  1  insert a bubble into ID/EX
- exe_stall  out  1  freeze ID/EX and EX/MEM
- ie_mfc0_hazard_stall  out  1  bubble into ID/EX for an EX mfc0 dependency
- im_mfc0_hazard_stall  out  1  bubble into ID/EX for a MEM mfc0 dependency
- int_flush  out  1  clear IF/ID and ID/EX
- ctrl_state  out  2  FSM state, for debug

Behaviour:
- Reset (resetn==0 at posedge):
  - state=RUN, div_cnt=0, flush_cnt=0.
  - All outputs are combinational from state and inputs; during reset every output except ctrl_state is forced to 0, and ctrl_state=0.
- Dependency terms:
  - rs_hit(r) = id_rs_used & id_rs==r & r!=0; rt_hit(r) is defined the same way for rt.
  - dep(r) = rs_hit(r) | rt_hit(r).
- FSM states:
  - RUN=0, DIV_WAIT=1, MEM_WAIT=2, FLUSH=3.
- Priority, evaluated every cycle from highest to lowest:
  1. cp0_ex_commit|cp0_eret: int_flush=1 this cycle, all stalls 0; next state=FLUSH with flush_cnt=FLUSH_CYCLES (stays RUN if FLUSH_CYCLES==0). This overrides every state, including DIV_WAIT (div_cnt is cleared) and MEM_WAIT.
  2. state==FLUSH: int_flush=1; flush_cnt decrements; go to RUN when it reaches 1→0.
  3. ram_wait: exe_stall=pc_stall=ifid_stall=1; state=MEM_WAIT, left on the first cycle ram_wait==0 (back to DIV_WAIT if div_cnt!=0, else RUN).
  4. state==DIV_WAIT: exe_stall=pc_stall=ifid_stall=1; div_cnt decrements; go to RUN on the cycle div_cnt becomes 0. The stall is therefore exactly DIV_CYCLES cycles long, counted from the cycle after div_issue.
  5. RUN & div_issue & no higher event: load div_cnt=DIV_CYCLES; state=DIV_WAIT. The issuing cycle itself is not stalled.
  6. ex_is_load & ex_rf_we & dep(ex_rd): hazard_stall=pc_stall=ifid_stall=1, for one cycle per occurrence.
  7. ex_is_mfc0 & ex_rf_we & dep(ex_rd): ie_mfc0_hazard_stall=pc_stall=ifid_stall=1.
  8. mem_is_mfc0 & mem_rf_we & dep(mem_rd): im_mfc0_hazard_stall=pc_stall=ifid_stall=1.
  - Items 6–8 may assert together. The bubble outputs are OR-independent.
- Mutual exclusion: exe_stall and any bubble output never assert in the same cycle; the freeze wins.
- Register $0 never causes a hazard.
- div_issue is ignored whenever it is not in RUN with no higher-priority event.
- Latency: all stall/flush outputs are combinational, so they are same-cycle relative to their inputs. State updates occur at the next posedge.

Optional Feature:
- Macro: PIPE_HAZARD_CTRL_PERF_EN.
- Defined:
  - Adds output perf_stall_cnt[31:0] and perf_flush_cnt[31:0].
  - perf_stall_cnt increments on each cycle in which pc_stall==1.
  - perf_flush_cnt increments on each cycle in which int_flush==1.
  - Both saturate at 32'hFFFF_FFFF and reset to 0.
- Undefined: neither port nor counters exist; the rest of the behaviour is identical.

Decomposition:
- Shared package pipe_ctrl_pkg:
  - state encodings ST_RUN/ST_DIV_WAIT/ST_MEM_WAIT/ST_FLUSH;
  - REG_ZERO=5'd0;
  - DIV_CYCLES default.
- One natural sub-module: hazard_dep_chk, a combinational rs/rt-vs-rd compare producing dep().
  - Instantiated three times: EX load, EX mfc0, MEM mfc0.

Test Plan:
- Load-use: ID reads rs=5, EX ex_is_load=1, ex_rd=5, ex_rf_we=1 → hazard_stall=pc_stall=ifid_stall=1 for exactly 1 cycle; repeat with ex_rd=0 → no stall.
- Divide: pulse div_issue in RUN, DIV_CYCLES=32 → exe_stall high for cycles 1..32 after the issue, then 0; ctrl_state=1 during the stall.
- RAM wait inside divide: ram_wait=1 for 3 cycles at div_cnt=10 → state=MEM_WAIT, div_cnt held at 10 throughout; afterwards DIV_WAIT resumes, with exe_stall continuous for the whole sequence.
- Exception mid-divide: cp0_ex_commit at div_cnt=20 → int_flush=1 that cycle plus 1 more (FLUSH_CYCLES=1), exe_stall=0, div_cnt=0, then RUN.
- Simultaneous: ex mfc0 dep on rt=7 and MEM mfc0 dep on rs=9 in the same cycle → ie_ and im_mfc0_hazard_stall both 1; adding ram_wait=1 → only exe_stall=1.
- Reset mid-FLUSH: resetn=0 for one cycle → all outputs 0, ctrl_state=0; with PIPE_HAZARD_CTRL_PERF_EN, both counters read 0.
